// File: rtl/pito_pkg.sv
// Shared types and constants for the pito-side AXI initiator bridge.
//
// Holds the bridge FSM state enum, the fixed AXI attribute constants and the
// soc crossbar channel structs (id 6, addr 32, data 32, user 1).
package pito_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } m2a_state_e;

    localparam logic [2:0]  M2A_SIZE_WORD    = 3'b010;
    localparam int unsigned M2A_RESP_ERR_BIT = 1;
    localparam logic [1:0]  M2A_BURST_INCR   = 2'b01;

    localparam int unsigned SocIdWidth   = 6;
    localparam int unsigned SocAddrWidth = 32;
    localparam int unsigned SocDataWidth = 32;
    localparam int unsigned SocUserWidth = 1;

    typedef struct packed {
        logic [SocIdWidth-1:0]   id;
        logic [SocAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [5:0]              atop;
        logic [SocUserWidth-1:0] user;
    } soc_aw_chan_t;

    typedef struct packed {
        logic [SocDataWidth-1:0]   data;
        logic [SocDataWidth/8-1:0] strb;
        logic                      last;
        logic [SocUserWidth-1:0]   user;
    } soc_w_chan_t;

    typedef struct packed {
        logic [SocIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [SocUserWidth-1:0] user;
    } soc_b_chan_t;

    typedef struct packed {
        logic [SocIdWidth-1:0]   id;
        logic [SocAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [SocUserWidth-1:0] user;
    } soc_ar_chan_t;

    typedef struct packed {
        logic [SocIdWidth-1:0]   id;
        logic [SocDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [SocUserWidth-1:0] user;
    } soc_r_chan_t;

    typedef struct packed {
        soc_aw_chan_t aw;
        logic         aw_valid;
        soc_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        soc_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } soc_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        soc_b_chan_t b;
        logic        r_valid;
        soc_r_chan_t r;
    } soc_resp_t;

endpackage

// File: rtl/pito_mem_to_axi_master.sv
// Initiator-side bridge: pito req/gnt/rvalid memory port -> AXI4 single-beat
// transactions, one outstanding at a time.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   mem_req_i/gnt_o     request handshake (gnt only while idle)
//   mem_we_i/addr_i/be_i/wdata_i   request payload, registered on gnt
//   mem_rvalid_o        one-cycle completion pulse (reads and writes)
//   mem_rdata_o         read data, held until the next read completes
//   mem_err_o           completion carried SLVERR/DECERR
//   axi_req_o/resp_i    AXI channels towards a crossbar slave port
//   err_sticky_o        (PITO_M2A_POSTED_WRITE_EN only) sticky posted-write error
//
// Build option: define PITO_M2A_POSTED_WRITE_EN to acknowledge writes the cycle
// after grant and finish AW/W/B in the background.
module pito_mem_to_axi_master
    import pito_pkg::*;
#(
    parameter int unsigned          AxiIdWidth   = 6,
    parameter int unsigned          AxiAddrWidth = 32,
    parameter int unsigned          AxiDataWidth = 32,
    parameter int unsigned          AxiUserWidth = 1,
    parameter logic [AxiIdWidth-1:0] AxiId       = '0,
    parameter type                  axi_req_t    = soc_req_t,
    parameter type                  axi_resp_t   = soc_resp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mem_req_i,
    output logic                    mem_gnt_o,
    input  logic                    mem_we_i,
    input  logic [AxiAddrWidth-1:0] mem_addr_i,
    input  logic [3:0]              mem_be_i,
    input  logic [31:0]             mem_wdata_i,
    output logic                    mem_rvalid_o,
    output logic [31:0]             mem_rdata_o,
    output logic                    mem_err_o,
`ifdef PITO_M2A_POSTED_WRITE_EN
    output logic                    err_sticky_o,
`endif
    output axi_req_t                axi_req_o,
    input  axi_resp_t               axi_resp_i
);

    if (AxiDataWidth != 32) begin : g_dw_check
        $error("pito_mem_to_axi_master supports only 32-bit data");
    end
    if (AxiUserWidth < 1) begin : g_uw_check
        $error("pito_mem_to_axi_master needs AxiUserWidth >= 1");
    end

    m2a_state_e              state_q;
    logic [AxiAddrWidth-1:0] addr_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    logic                    aw_done_q;
    logic                    w_done_q;
    logic [31:0]             rdata_q;
    logic                    err_q;
`ifdef PITO_M2A_POSTED_WRITE_EN
    logic                    posted_q;
    logic                    err_sticky_q;
`endif

    // Valids are only high while the matching done flag is clear, so OR-ing in
    // the raw ready is the same as OR-ing in the handshake.
    logic aw_done_nx, w_done_nx;
    assign aw_done_nx = aw_done_q | axi_resp_i.aw_ready;
    assign w_done_nx  = w_done_q  | axi_resp_i.w_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
`ifdef PITO_M2A_POSTED_WRITE_EN
            posted_q     <= 1'b0;
            err_sticky_q <= 1'b0;
`endif
        end else begin
`ifdef PITO_M2A_POSTED_WRITE_EN
            posted_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (mem_req_i) begin
                        addr_q    <= {mem_addr_i[AxiAddrWidth-1:2], 2'b00};
                        be_q      <= mem_be_i;
                        wdata_q   <= mem_wdata_i;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        err_q     <= 1'b0;
                        state_q   <= mem_we_i ? StWr : StRdAddr;
`ifdef PITO_M2A_POSTED_WRITE_EN
                        posted_q  <= mem_we_i;
`endif
                    end
                end
                StWr: begin
                    aw_done_q <= aw_done_nx;
                    w_done_q  <= w_done_nx;
                    if (aw_done_nx && w_done_nx) begin
                        state_q <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (axi_resp_i.b_valid) begin
`ifdef PITO_M2A_POSTED_WRITE_EN
                        // Completion was already reported; only the sticky flag
                        // can carry the error now.
                        err_sticky_q <= err_sticky_q | axi_resp_i.b.resp[M2A_RESP_ERR_BIT];
                        state_q      <= StIdle;
`else
                        err_q   <= axi_resp_i.b.resp[M2A_RESP_ERR_BIT];
                        state_q <= StDone;
`endif
                    end
                end
                StRdAddr: begin
                    if (axi_resp_i.ar_ready) begin
                        state_q <= StRdData;
                    end
                end
                StRdData: begin
                    if (axi_resp_i.r_valid) begin
                        rdata_q <= axi_resp_i.r.data;
                        err_q   <= axi_resp_i.r.resp[M2A_RESP_ERR_BIT];
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_gnt_o   = mem_req_i && (state_q == StIdle);
    assign mem_rdata_o = rdata_q;
    assign mem_err_o   = err_q;
`ifdef PITO_M2A_POSTED_WRITE_EN
    assign mem_rvalid_o = (state_q == StDone) || posted_q;
    assign err_sticky_o = err_sticky_q;
`else
    assign mem_rvalid_o = (state_q == StDone);
`endif

    always_comb begin
        axi_req_o = '0;

        axi_req_o.aw.id    = AxiId;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.size  = M2A_SIZE_WORD;
        axi_req_o.aw.burst = M2A_BURST_INCR;
        axi_req_o.aw_valid = (state_q == StWr) && !aw_done_q;

        axi_req_o.w.data   = wdata_q;
        axi_req_o.w.strb   = be_q;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = (state_q == StWr) && !w_done_q;

        axi_req_o.b_ready  = (state_q == StWrResp);

        axi_req_o.ar.id    = AxiId;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.size  = M2A_SIZE_WORD;
        axi_req_o.ar.burst = M2A_BURST_INCR;
        axi_req_o.ar_valid = (state_q == StRdAddr);

        axi_req_o.r_ready  = (state_q == StRdData);
    end

    logic unused_bits;
    assign unused_bits = ^{mem_addr_i[1:0], axi_resp_i.b.id, axi_resp_i.b.resp[0],
                           axi_resp_i.b.user, axi_resp_i.r.id, axi_resp_i.r.resp[0],
                           axi_resp_i.r.last, axi_resp_i.r.user};

endmodule

// File: tb/tb_pito_mem_to_axi_master.sv
`timescale 1ns/1ps
module tb_pito_mem_to_axi_master;
    import pito_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_gnt;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_be = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
`ifdef PITO_M2A_POSTED_WRITE_EN
    logic        err_sticky;
`endif
    soc_req_t    axi_req;
    soc_resp_t   axi_resp;

    always #5 clk = ~clk;

    pito_mem_to_axi_master dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_req_i    (mem_req),
        .mem_gnt_o    (mem_gnt),
        .mem_we_i     (mem_we),
        .mem_addr_i   (mem_addr),
        .mem_be_i     (mem_be),
        .mem_wdata_i  (mem_wdata),
        .mem_rvalid_o (mem_rvalid),
        .mem_rdata_o  (mem_rdata),
        .mem_err_o    (mem_err),
`ifdef PITO_M2A_POSTED_WRITE_EN
        .err_sticky_o (err_sticky),
`endif
        .axi_req_o    (axi_req),
        .axi_resp_i   (axi_resp)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus record: request, slave behaviour, and expected completion.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        slv_err;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          gcyc;
    } sb_t;

    vec_t vecs[15];
    vec_t slv_q[$];
    sb_t  sb_q[$];
    int   cur_idx = 0;
    logic [31:0] last_rd = '0;
    bit   b2b = 1'b0;
    int   last_gnt = -1;
    int   n_rv = 0;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic slv_err, input int aw, input int w, input int b,
                                input int ar, input int r, input logic exp_err,
                                input int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.be = be; v.wdata = wdata; v.rdata = rdata;
        v.slv_err = slv_err; v.aw_dly = aw; v.w_dly = w; v.b_dly = b;
        v.ar_dly = ar; v.r_dly = r; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Slave-side decode: top nibble non-zero is outside the map -> DECERR.
    function automatic logic [1:0] resp_of(input vec_t v);
        if (v.addr[31:28] != 4'h0) return 2'b11;
        return v.slv_err ? 2'b10 : 2'b00;
    endfunction

    // ---------------- AXI slave model ----------------
    bit aw_seen, w_seen, b_pend, r_pend;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

    initial begin : slave
        vec_t cfg;
        bit   have;
        axi_resp = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                axi_resp = '0;
                aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                continue;
            end
            have = (slv_q.size() != 0);
            axi_resp = '0;
            if (have) begin
                cfg = slv_q[0];
                axi_resp.aw_ready = axi_req.aw_valid && (aw_cnt >= cfg.aw_dly);
                axi_resp.w_ready  = axi_req.w_valid && (w_cnt >= cfg.w_dly);
                axi_resp.ar_ready = axi_req.ar_valid && (ar_cnt >= cfg.ar_dly);
                axi_resp.b_valid  = b_pend && (b_cnt >= cfg.b_dly);
                axi_resp.b.resp   = resp_of(cfg);
                axi_resp.r_valid  = r_pend && (r_cnt >= cfg.r_dly);
                axi_resp.r.resp   = resp_of(cfg);
                axi_resp.r.data   = cfg.rdata;
                axi_resp.r.last   = 1'b1;
            end
            @(negedge clk);
            if (rst) continue;
            if (!have) begin
                if (axi_req.aw_valid || axi_req.w_valid || axi_req.ar_valid)
                    chk("axi_valid_without_grant", 1, 0);
                continue;
            end
            if (axi_req.aw_valid) begin
                chk("aw_for_write", cfg.we, 1);
                chk("aw_once", aw_seen, 0);
                chk("aw_addr", axi_req.aw.addr, cfg.addr & 32'hFFFF_FFFC);
                if (axi_resp.aw_ready) begin
                    chk("aw_len", axi_req.aw.len, 0);
                    chk("aw_size", axi_req.aw.size, 2);
                    chk("aw_burst", axi_req.aw.burst, 1);
                    chk("aw_id", axi_req.aw.id, 0);
                    aw_seen = 1; aw_cnt = 0;
                end else aw_cnt++;
            end
            if (axi_req.w_valid) begin
                chk("w_once", w_seen, 0);
                chk("w_data", axi_req.w.data, cfg.wdata);
                chk("w_strb", axi_req.w.strb, cfg.be);
                if (axi_resp.w_ready) begin
                    chk("w_last", axi_req.w.last, 1);
                    w_seen = 1; w_cnt = 0;
                end else w_cnt++;
            end
            if (b_pend) begin
                if (axi_resp.b_valid && axi_req.b_ready) begin
                    b_pend = 0; aw_seen = 0; w_seen = 0;
                    void'(slv_q.pop_front());
                end else b_cnt++;
            end else if (aw_seen && w_seen) begin
                b_pend = 1; b_cnt = 0;
            end
            if (r_pend) begin
                if (axi_resp.r_valid && axi_req.r_ready) begin
                    r_pend = 0;
                    void'(slv_q.pop_front());
                end else r_cnt++;
            end
            if (axi_req.ar_valid) begin
                chk("ar_for_read", cfg.we, 0);
                chk("ar_addr", axi_req.ar.addr, cfg.addr & 32'hFFFF_FFFC);
                if (axi_resp.ar_ready) begin
                    chk("ar_len", axi_req.ar.len, 0);
                    chk("ar_size", axi_req.ar.size, 2);
                    r_pend = 1; r_cnt = 0; ar_cnt = 0;
                end else ar_cnt++;
            end
        end
    end

    // ---------------- grant / completion monitor ----------------
    initial begin : monitor
        sb_t e;
        bit  prev_rv = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rvalid_in_reset", mem_rvalid, 0);
                prev_rv = 0;
                continue;
            end
            if (mem_gnt) begin
                chk("gnt_only_idle", sb_q.size(), 0);
                if (b2b && last_gnt >= 0) chk("gnt_gap", cyc - last_gnt, 4);
                last_gnt = cyc;
                e.we = vecs[cur_idx].we; e.rdata = vecs[cur_idx].rdata;
                e.err = vecs[cur_idx].exp_err; e.lat = vecs[cur_idx].exp_lat; e.gcyc = cyc;
                sb_q.push_back(e);
                slv_q.push_back(vecs[cur_idx]);
            end
            if (mem_rvalid) begin
                n_rv++;
                chk("rvalid_one_cycle", prev_rv, 0);
                if (sb_q.size() == 0) chk("spurious_rvalid", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("err", mem_err, e.err);
                    chk("latency", cyc - e.gcyc, e.lat);
                    if (!e.we) begin
                        if (!e.err) chk("rdata", mem_rdata, e.rdata);
                        last_rd = mem_rdata;
                    end else chk("rdata_held", mem_rdata, last_rd);
                end
            end
            prev_rv = mem_rvalid;
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input int i);
        cur_idx   = i;
        mem_we    = vecs[i].we;
        mem_addr  = vecs[i].addr;
        mem_be    = vecs[i].be;
        mem_wdata = vecs[i].wdata;
    endtask

    task automatic wait_gnt();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_gnt) break;
        end
        chk("gnt_timeout", k < 100, 1);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
        chk("done_timeout", k < 100, 1);
        @(negedge clk);
    endtask

    task automatic run_one(input int i);
        @(posedge clk); #1;
        drive(i);
        mem_req = 1'b1;
        wait_gnt();
        @(posedge clk); #1;
        mem_req = 1'b0;
        wait_done();
    endtask

    initial begin : main
        int k, rv0;
        //              we  addr          be    wdata         rdata         se aw w  b  ar r  err lat
        vecs[0]  = mk(0, 32'h0020_2004, 4'h0, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[1]  = mk(1, 32'h0020_0010, 4'h3, 32'h1234_5678, 32'h0,        0, 2, 0, 0, 0, 0, 0, 5);
        vecs[2]  = mk(1, 32'h1000_0000, 4'hF, 32'hAAAA_5555, 32'h0,        0, 0, 0, 0, 0, 0, 1, 3);
        vecs[3]  = mk(0, 32'h0000_0103, 4'h0, 32'h0,        32'hA5A5_0001, 0, 0, 0, 0, 1, 2, 0, 6);
        vecs[4]  = mk(1, 32'h0020_0020, 4'h0, 32'h0F0F_F0F0, 32'h0,        0, 0, 3, 2, 0, 0, 0, 8);
        vecs[5]  = mk(0, 32'h0020_0030, 4'h0, 32'h0,        32'h0BAD_F00D, 1, 0, 0, 0, 0, 0, 1, 3);
        vecs[6]  = mk(0, 32'h2000_0008, 4'h0, 32'h0,        32'h7777_7777, 0, 0, 0, 0, 0, 0, 1, 3);
        vecs[7]  = mk(1, 32'h0020_0041, 4'h8, 32'hFEED_0007, 32'h0,        0, 1, 1, 0, 0, 0, 0, 4);
        vecs[8]  = mk(0, 32'h0020_0000, 4'h0, 32'h0,        32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[9]  = mk(1, 32'h0020_0004, 4'hF, 32'h2222_2222, 32'h0,        0, 0, 0, 0, 0, 0, 0, 3);
        vecs[10] = mk(0, 32'h0020_0008, 4'h0, 32'h0,        32'h3333_3333, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[11] = mk(1, 32'h0020_000C, 4'h5, 32'h4444_4444, 32'h0,        0, 0, 0, 0, 0, 0, 0, 3);
        vecs[12] = mk(0, 32'h0020_2008, 4'h0, 32'h0,        32'h9999_9999, 0, 0, 0, 0, 0, 10, 0, 13);
        vecs[13] = mk(0, 32'h0020_2010, 4'h0, 32'h0,        32'hCAFE_0013, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[14] = mk(1, 32'h0020_0014, 4'hF, 32'h5555_0014, 32'h0,        0, 0, 0, 0, 0, 0, 0, 3);

        // Reset state.
        #12;
        chk("rst_gnt", mem_gnt, 0);
        chk("rst_rvalid", mem_rvalid, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_aw_valid", axi_req.aw_valid, 0);
        chk("rst_w_valid", axi_req.w_valid, 0);
        chk("rst_b_ready", axi_req.b_ready, 0);
        chk("rst_ar_valid", axi_req.ar_valid, 0);
        chk("rst_r_ready", axi_req.r_ready, 0);
        chk("rst_aw_addr", axi_req.aw.addr, 0);
        chk("rst_w_data", axi_req.w.data, 0);
        @(posedge clk); #3;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_one(i);

        // Back-to-back: req held high across four transactions.
        rv0 = n_rv;
        last_gnt = -1;
        @(posedge clk); #1;
        b2b = 1'b1;
        drive(8);
        mem_req = 1'b1;
        for (int j = 8; j < 12; j++) begin
            wait_gnt();
            @(posedge clk); #1;
            if (j < 11) drive(j + 1);
            else mem_req = 1'b0;
        end
        wait_done();
        b2b = 1'b0;
        chk("b2b_rvalid_count", n_rv - rv0, 4);

        // Reset while waiting for R: transaction dropped, no completion.
        @(posedge clk); #1;
        drive(12);
        mem_req = 1'b1;
        wait_gnt();
        @(posedge clk); #1;
        mem_req = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (axi_req.r_ready) break;
        end
        chk("reach_rd_data", k < 20, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_r_ready", axi_req.r_ready, 0);
        chk("arst_ar_valid", axi_req.ar_valid, 0);
        chk("arst_rvalid", mem_rvalid, 0);
        chk("arst_rdata", mem_rdata, 0);
        chk("arst_err", mem_err, 0);
        sb_q.delete();
        slv_q.delete();
        last_rd = '0;
        @(posedge clk); #3;
        rst = 1'b0;
        rv0 = n_rv;
        repeat (5) @(posedge clk);
        chk("no_rvalid_after_reset", n_rv - rv0, 0);
        run_one(13);
        run_one(14);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
